// File: rtl/uc_pkg.sv
// Shared definitions for the multicycle control unit: major-opcode codes,
// FSM state encoding and the control word driven into the datapath.
package uc_pkg;

  // Major opcode field is opcode[5:2] when the ALU class bit is clear
  localparam int         ALU_CLASS_BIT = 5;
  localparam logic [3:0] OP_LI   = 4'b0000;
  localparam logic [3:0] OP_J    = 4'b0001;
  localparam logic [3:0] OP_JZ   = 4'b0010;
  localparam logic [3:0] OP_JNZ  = 4'b0011;
  localparam logic [3:0] OP_NOP  = 4'b0100;
  localparam logic [3:0] OP_HALT = 4'b0101;

  typedef logic [1:0] state_t;
  localparam state_t ST_INIT   = 2'd0;
  localparam state_t ST_RUN    = 2'd1;
  localparam state_t ST_HALTED = 2'd2;
  localparam state_t ST_STEP   = 2'd3;

  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       we;
    logic       wez;
    logic [2:0] alu_op;
  } ctrl_t;

  // Safe word while not executing: PC holds, nothing written
  localparam ctrl_t CTRL_IDLE = '{s_inc: 1'b1, s_inm: 1'b0, we: 1'b0,
                                  wez: 1'b0, alu_op: 3'b000};

endpackage

// File: rtl/uc_decoder.sv
// Purely combinational instruction decode: opcode + zero flag to the
// datapath control word, plus HALT and undefined-opcode indications.
module uc_decoder
  import uc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       zero,
  output ctrl_t      ctrl,
  output logic       is_halt,
  output logic       is_illegal
);

  logic [3:0] major;
  assign major = opcode[5:2];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    ctrl       = CTRL_IDLE;
    is_halt    = 1'b0;
    is_illegal = 1'b0;

    if (opcode[ALU_CLASS_BIT]) begin
      ctrl.alu_op = opcode[4:2];
      ctrl.we     = 1'b1;
      ctrl.wez    = 1'b1;
    end else begin
      case (major)
        OP_LI: begin
          ctrl.s_inm = 1'b1;
          ctrl.we    = 1'b1;
        end
        OP_J:    ctrl.s_inc = 1'b0;
        // Conditional jumps: s_inc low selects the jump target
        OP_JZ:   ctrl.s_inc = ~zero;
        OP_JNZ:  ctrl.s_inc = zero;
        OP_NOP:  ;
        OP_HALT: is_halt = 1'b1;
        default: is_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/uc_multiciclo_ctrl.sv
// Run/halt/single-step control unit for the microc datapath: state-gated
// decode, sticky illegal-opcode flag and a retired-instruction counter.
module uc_multiciclo_ctrl
  import uc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             run_req,
  input  logic             step_req,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we,
  output logic             wez,
  output logic [2:0]       ALUOp,
  output logic             pc_en,
  output logic             halted,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  state_t state;
  state_t state_nxt;
  ctrl_t  dec_ctrl;
  ctrl_t  ctrl;
  logic   dec_halt;
  logic   dec_illegal;
  logic   exec;

  uc_decoder u_decoder (
    .opcode     (opcode),
    .zero       (zero),
    .ctrl       (dec_ctrl),
    .is_halt    (dec_halt),
    .is_illegal (dec_illegal)
  );

  assign exec = (state == ST_RUN) || (state == ST_STEP);

  // Decode is only allowed through while executing
  always_comb begin
    ctrl = CTRL_IDLE;
    if (exec) ctrl = dec_ctrl;
  end

  assign s_inc  = ctrl.s_inc;
  assign s_inm  = ctrl.s_inm;
  assign we     = ctrl.we;
  assign wez    = ctrl.wez;
  assign ALUOp  = ctrl.alu_op;
  assign pc_en  = exec;
  assign halted = (state == ST_HALTED);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: state_nxt = ST_RUN;
      ST_RUN:  if (dec_halt) state_nxt = ST_HALTED;
      // A step always returns to HALTED, even when it executed HALT
      ST_STEP: state_nxt = ST_HALTED;
      ST_HALTED: begin
        if (run_req)       state_nxt = ST_RUN;
        else if (step_req) state_nxt = ST_STEP;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state       <= ST_INIT;
      illegal_op  <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (exec) begin
        instr_count <= instr_count + CNT_W'(1);
        if (dec_illegal) illegal_op <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uc_multiciclo_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized run/step/reset traffic checked against a behavioural model.
module tb_uc_multiciclo_ctrl;

  localparam int CNT_W = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  localparam int M_INIT = 0, M_RUN = 1, M_HALTED = 2, M_STEP = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       opcode;
  logic             zero;
  logic             run_req;
  logic             step_req;
  logic             s_inc, s_inm, we, wez, pc_en, halted, illegal_op;
  logic [2:0]       ALUOp;
  logic [CNT_W-1:0] instr_count;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int mode;
  int m_cnt;
  bit m_ill;
  bit model_valid = 1'b0;

  uc_multiciclo_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .zero        (zero),
    .run_req     (run_req),
    .step_req    (step_req),
    .s_inc       (s_inc),
    .s_inm       (s_inm),
    .we          (we),
    .wez         (wez),
    .ALUOp       (ALUOp),
    .pc_en       (pc_en),
    .halted      (halted),
    .illegal_op  (illegal_op),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: executing instructions classified by plain opcode arithmetic
  function automatic bit m_exec();
    return (mode == M_RUN) || (mode == M_STEP);
  endfunction

  function automatic int major_of(input logic [5:0] op);
    return int'(op) / 4;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mode        <= M_INIT;
      m_cnt       <= 0;
      m_ill       <= 1'b0;
      model_valid <= 1'b1;
    end else if (model_valid) begin
      if (m_exec()) begin
        m_cnt <= (m_cnt + 1) % CNT_MOD;
        if (major_of(opcode) == 6 || major_of(opcode) == 7) m_ill <= 1'b1;
      end
      case (mode)
        M_INIT:   mode <= M_RUN;
        M_RUN:    if (major_of(opcode) == 5) mode <= M_HALTED;
        M_STEP:   mode <= M_HALTED;
        default:  mode <= run_req ? M_RUN : (step_req ? M_STEP : M_HALTED);
      endcase
    end
  end

  // Compare every cycle, half a period away from the active edge
  always @(negedge clk) begin
    if (model_valid) begin
      bit x_inc, x_inm, x_we, x_wez;
      int x_alu, mj;
      bit alu;
      x_inc = 1'b1; x_inm = 1'b0; x_we = 1'b0; x_wez = 1'b0; x_alu = 0;
      alu = (opcode >= 6'd32);
      mj  = major_of(opcode);
      if (m_exec()) begin
        if (alu) begin
          x_we = 1'b1; x_wez = 1'b1; x_alu = mj - 8;
        end else if (mj == 0) begin
          x_we = 1'b1; x_inm = 1'b1;
        end else if (mj == 1) x_inc = 1'b0;
        else if (mj == 2) x_inc = !zero;
        else if (mj == 3) x_inc = zero;
      end
      check("m_s_inc", 32'(s_inc), 32'(x_inc));
      check("m_s_inm", 32'(s_inm), 32'(x_inm));
      check("m_we", 32'(we), 32'(x_we));
      check("m_wez", 32'(wez), 32'(x_wez));
      check("m_aluop", 32'(ALUOp), 32'(x_alu));
      check("m_pc_en", 32'(pc_en), 32'(m_exec()));
      check("m_halted", 32'(halted), 32'(mode == M_HALTED));
      check("m_illegal", 32'(illegal_op), 32'(m_ill));
      check("m_count", 32'(instr_count), 32'(m_cnt));
    end
  end

  initial begin
    reset = 1'b1; opcode = 6'b100100; zero = 1'b0; run_req = 1'b0; step_req = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    check("init_pc_en", 32'(pc_en), 0);
    check("init_we", 32'(we), 0);
    check("init_count", 32'(instr_count), 0);
    tick();
    @(negedge clk);
    check("alu_op", 32'(ALUOp), 1);
    check("alu_we", 32'(we), 1);
    check("alu_wez", 32'(wez), 1);
    check("alu_pc_en", 32'(pc_en), 1);
    tick(); opcode = 6'b001000; zero = 1'b1;
    @(negedge clk);
    check("count_after_alu", 32'(instr_count), 1);
    check("jz_taken", 32'(s_inc), 0);
    check("jz_we", 32'(we | wez), 0);
    tick(); zero = 1'b0;
    @(negedge clk); check("jz_not_taken", 32'(s_inc), 1);
    tick(); opcode = 6'b001100; zero = 1'b1;
    @(negedge clk); check("jnz_z1", 32'(s_inc), 1);
    tick(); zero = 1'b0;
    @(negedge clk); check("jnz_z0", 32'(s_inc), 0);
    tick(); opcode = 6'b010100;
    @(negedge clk);
    check("halt_pc_en", 32'(pc_en), 1);
    check("halt_count", 32'(instr_count), 5);
    tick(); opcode = 6'b000000;
    @(negedge clk);
    check("halted_flag", 32'(halted), 1);
    check("halted_pc_en", 32'(pc_en), 0);
    check("halted_count", 32'(instr_count), 6);
    tick(); step_req = 1'b1;
    @(negedge clk); check("halted_hold", 32'(halted), 1);
    tick(); step_req = 1'b0;
    @(negedge clk);
    check("step_inm", 32'(s_inm), 1);
    check("step_we", 32'(we), 1);
    check("step_halted", 32'(halted), 0);
    tick();
    @(negedge clk);
    check("step_back_halted", 32'(halted), 1);
    check("step_count", 32'(instr_count), 7);
    run_req = 1'b1; step_req = 1'b1;
    tick(); run_req = 1'b0; step_req = 1'b0; opcode = 6'b010000;
    @(negedge clk);
    check("run_wins", 32'(halted), 0);
    check("run_pc_en", 32'(pc_en), 1);
    tick(); opcode = 6'b011000;
    @(negedge clk);
    check("ill_we", 32'(we | wez), 0);
    check("ill_pc_en", 32'(pc_en), 1);
    tick(); opcode = 6'b111100;
    @(negedge clk); check("ill_sticky", 32'(illegal_op), 1);
    tick();
    @(negedge clk); check("ill_sticky2", 32'(illegal_op), 1);
    reset = 1'b1; opcode = 6'b010000;
    tick();
    @(negedge clk);
    check("rst_count", 32'(instr_count), 0);
    check("rst_pc_en", 32'(pc_en), 0);
    check("rst_we", 32'(we), 0);
    check("rst_illegal", 32'(illegal_op), 0);
    // Counter wrap: 16 executed NOPs from zero
    reset = 1'b0;
    tick();
    repeat (15) tick();
    @(negedge clk); check("cnt_15", 32'(instr_count), 15);
    tick();
    @(negedge clk); check("cnt_wrap", 32'(instr_count), 0);

    // Randomized traffic, the model checks every cycle
    for (int i = 0; i < 4000; i++) begin
      tick();
      opcode   = 6'($urandom_range(0, 63));
      zero     = 1'($urandom_range(0, 1));
      run_req  = ($urandom_range(0, 7) == 0);
      step_req = ($urandom_range(0, 2) == 0);
      reset    = ($urandom_range(0, 199) == 0);
    end
    tick();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uc_multiciclo_ctrl.md
Name: uc_multiciclo_ctrl

Overview:
Control unit that sits directly downstream of the microc datapath.
- Consumes the datapath's Opcode and zero outputs.
- Produces the datapath's control inputs: s_inc, s_inm, we, wez, ALUOp, plus a PC load enable.
- Adds run/halt/single-step sequencing, an illegal-opcode flag and a retired-instruction counter, for bring-up and debug of the single-cycle core.

Parameters:
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
opcode  in  6  current instruction opcode from the datapath
zero  in  1  registered zero flag from the datapath
run_req  in  1  leave HALTED and free-run (level, sampled each cycle)
step_req  in  1  from HALTED, execute exactly one instruction
s_inc  out  1  PC mux select: 1 = PC+1, 0 = jump target
s_inm  out  1  register-file write data: 1 = immediate, 0 = ALU result
we  out  1  register-file write enable
wez  out  1  zero-flag write enable
ALUOp  out  3  ALU operation select
pc_en  out  1  PC register load enable
halted  out  1  1 while in HALTED
illegal_op  out  1  sticky flag: an undefined opcode was executed
instr_count  out  CNT_W  instructions retired, wraps modulo 2^CNT_W

Behaviour:
- Only clk is used; reset is synchronous, active-high, and overrides every other input, including mid-instruction.
- Control outputs are a combinational decode of opcode, zero and the current state, because the datapath needs them in the same cycle.
- State, illegal_op and instr_count are registered.
- Decode, when executing (state RUN or STEP):
  - opcode[5]=1: ALU reg-reg. ALUOp=opcode[4:2], s_inm=0, we=1, wez=1, s_inc=1.
  - opcode[5:2]=0000: LI. s_inm=1, we=1, wez=0, ALUOp=000, s_inc=1.
  - 0001: J. s_inc=0, we=0, wez=0.
  - 0010: JZ. s_inc=~zero.
  - 0011: JNZ. s_inc=zero.
  - 0100: NOP. s_inc=1, no writes.
  - 0101: HALT. s_inc=1, no writes, next state HALTED.
  - 0110-0111: illegal. Behaves as NOP; illegal_op<=1.
  - Executing cycle always has pc_en=1.
- Non-executing state (INIT, HALTED): pc_en=0, we=0, wez=0, s_inc=1, s_inm=0, ALUOp=000.
- Reset values: state=INIT, halted=0, illegal_op=0, instr_count=0. Control outputs take the non-executing values above.
- FSM:
  - INIT: one dead cycle after reset, lets the datapath settle. Goes to RUN unconditionally.
  - RUN: executes every cycle. HALT opcode -> HALTED; otherwise stay.
  - HALTED: halted=1. run_req -> RUN. Else step_req -> STEP. Else stay. If both are high, run_req wins.
  - STEP: executes one instruction, then -> HALTED, including when that instruction is HALT.
- HALT advances the PC, so resuming executes the instruction after HALT. Halt-on-HALT cannot livelock.
- instr_count increments by 1 on every executing cycle (RUN or STEP), including HALT and illegal opcodes. It wraps from 2^CNT_W-1 to 0.
- illegal_op is cleared only by reset.
- Jumps whose branch is not taken still count as retired.

Decomposition:
- Shared package uc_pkg holds:
  - major-opcode constants: OP_LI, OP_J, OP_JZ, OP_JNZ, OP_NOP, OP_HALT, ALU class bit;
  - state typedef: INIT, RUN, HALTED, STEP;
  - the non-executing control default vector.
- Sub-module uc_decoder: purely combinational opcode+zero -> {s_inc, s_inm, we, wez, ALUOp, is_halt, is_illegal}.
- Top module holds the FSM, the counter and the state-based gating.

Test Plan:
- Reset 2 cycles, then opcode=6'b100100, zero=0 -> INIT cycle with pc_en=0, we=0. Next cycle ALUOp=001, we=1, wez=1, s_inc=1, pc_en=1. instr_count=1 after that edge.
- JZ (6'b001000) with zero=1 -> s_inc=0. With zero=0 -> s_inc=1. JNZ (6'b001100) gives the inverse. we=wez=0 in all cases.
- HALT (6'b010100) in RUN -> pc_en=1 that cycle, then halted=1, pc_en=0 while run_req=step_req=0. Pulse step_req with LI (6'b000000) -> one cycle s_inm=1, we=1, then back to halted=1. instr_count advances by exactly 1.
- In HALTED, run_req=1 and step_req=1 in the same cycle -> enters RUN (halted=0) and keeps executing.
- Opcode 6'b011000 -> no writes, pc_en=1, illegal_op=1. illegal_op stays 1 through later legal opcodes until reset.
- CNT_W=4, 16 executing cycles from 0 -> instr_count wraps to 0. Assert reset mid-RUN -> next cycle state INIT, instr_count=0, all enables 0.
